lfsr_draw_arbiter: RTL
======================

Name: lfsr_draw_arbiter

Overview:
- Owns one 32-bit Fibonacci LFSR (taps 31,28,20,13,9,8,1; shift left, feedback into bit 0) and shares it among NREQ game requesters, e.g. pipe-gap height, cloud position and sound jitter.
- Arbitrates requests round-robin and steps the LFSR STEPS times per draw to decorrelate consecutive draws.
- Range-limits each draw to [0, LIMIT) by bounded rejection sampling.
- Sits between the game-logic blocks and the random source and replaces direct LFSR instantiation per requester.

Parameters:
- NREQ, 4, number of requesters.
- OUT_W, 8, width of the returned random value.
- LIMIT, 200, exclusive upper bound of the returned value. Must satisfy 2^(OUT_W-1) < LIMIT <= 2^OUT_W.
- STEPS, 8, LFSR shifts per draw attempt (>=1).
- MAX_TRIES, 4, draw attempts before fallback (>=1).
- SEED, 32'hACE12468, reset seed and substitute for a zero seed (nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- seed_load  in  1  load seed_in into the LFSR (honoured in IDLE only).
- seed_in  in  32  seed value.
- req  in  NREQ  per-requester draw request, level, held until own gnt.
- gnt  out  NREQ  one-hot, asserted for exactly the rnd_valid cycle.
- rnd_valid  out  1  one-cycle pulse, rnd_data valid.
- rnd_data  out  OUT_W  drawn value, < LIMIT, held until next rnd_valid.
- busy  out  1  high in every state except IDLE.
- lfsr_state  out  32  current LFSR register (debug/observe).

Behaviour:
- Reset (async, any state) sets:
  - LFSR = SEED, state = IDLE.
  - gnt = 0, rnd_valid = 0, rnd_data = 0, busy = 0.
  - Round-robin pointer: requester 0 has top priority.
  - Step and try counters = 0.
- Registered outputs; LFSR shifts only in SHIFT.
- States:
  - IDLE:
    - If seed_load: LFSR = seed_in, or SEED if seed_in == 0. Stay IDLE. seed_load beats a simultaneous req; that req is serviced next cycle.
    - Else if any req bit is set: latch winner = first set bit searching upward (wrapping) from last granted + 1. Set step counter = STEPS, tries = 0, go to SHIFT.
  - SHIFT: one LFSR shift per cycle, decrement counter. After the STEPS-th shift go to CHECK.
  - CHECK: cand = LFSR[OUT_W-1:0].
    - If cand < LIMIT: result = cand, go to DONE.
    - Else if tries == MAX_TRIES-1: result = cand - LIMIT (fits by the parameter rule), go to DONE.
    - Else: tries++, counter = STEPS, go to SHIFT.
  - DONE:
    - rnd_valid = 1, gnt = one-hot(winner), rnd_data = result.
    - Update round-robin pointer to winner. Go to IDLE.
- Latency:
  - req sampled in IDLE at cycle 0 gives rnd_valid at cycle STEPS+2 (10 with defaults).
  - Each rejection adds STEPS+1 cycles. Worst case is MAX_TRIES*(STEPS+1)+1.
- Back-to-back: at most one grant per STEPS+3 cycles. IDLE is always visited for one cycle between grants.
- Request semantics:
  - req deasserted mid-service: the draw still completes and gnt still pulses; the requester ignores it.
  - New req bits arriving mid-service wait for the next IDLE.
- seed_load outside IDLE: ignored, no effect on the draw in progress.
- LFSR never holds zero: reset, zero-seed substitution and a nonzero shift function guarantee it.
- Reset mid-draw: no rnd_valid/gnt pulse is emitted. After reset the LFSR is back to SEED and the pointer is back to requester 0.

Test Plan:
- Reset, then req=4'b0001 held: rnd_valid at cycle 10 with gnt=4'b0001 and rnd_data<200. lfsr_state equals the reference model after 8 shifts from 32'hACE12468. busy is high for cycles 1..10.
- req=4'b1111 held continuously: gnt sequence 0001,0010,0100,1000,0001. Each grant is 11+ cycles apart, never two bits set.
- seed_load=1 with seed_in=0 in IDLE: lfsr_state=32'hACE12468 next cycle. seed_load=1 with seed_in=32'h1 and req=4'b0010 in the same cycle: seed loaded first, grant to requester 1 at cycle 11.
- Rejection path: a seed chosen via the model so the first cand is >= 200. rnd_valid arrives 9 cycles later than baseline (19) with the model value. A seed forcing 4 rejects gives rnd_data = cand-200 at cycle 37.
- rst pulsed during SHIFT of a draw: no gnt/rnd_valid. Outputs are 0 and lfsr_state=32'hACE12468 immediately. A subsequent req=4'b0100 is granted normally.
- 10000 random-request draws vs model: every rnd_data<200, all values match bit-exactly, and no requester waits longer than 3 other grants.

Source files
------------

// File: rtl/lfsr_draw_arbiter.sv
// rtl/lfsr_draw_arbiter.sv - round-robin shared LFSR with range-limited draws
module lfsr_draw_arbiter #(
    parameter int          NREQ      = 4,
    parameter int          OUT_W     = 8,
    parameter int          LIMIT     = 200,
    parameter int          STEPS     = 8,
    parameter int          MAX_TRIES = 4,
    parameter logic [31:0] SEED      = 32'hACE12468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             rnd_valid,
    output logic [OUT_W-1:0] rnd_data,
    output logic             busy,
    output logic [31:0]      lfsr_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(STEPS + 1);
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [OUT_W:0] LIM = (OUT_W + 1)'(LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic [PW-1:0]    last_q, last_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;

    logic             rr_found;
    logic [PW-1:0]    rr_win;
    logic [PW-1:0]    rr_idx;
    logic [OUT_W-1:0] cand;
    logic             cand_ok;
    logic [OUT_W-1:0] cand_wrap;

    // Fibonacci step: shift left, XOR of taps 31,28,20,13,9,8,1 enters at bit 0.
    // A nonzero state never maps to zero, so the register cannot lock up.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[28] ^ x[20] ^ x[13] ^ x[9] ^ x[8] ^ x[1]};
    endfunction

    // Round-robin search: first set req bit upward from the last grant, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = last_q;
        rr_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = PW'((int'(last_q) + i) % NREQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    assign cand      = lfsr_q[OUT_W-1:0];
    assign cand_ok   = ({1'b0, cand} < LIM);
    assign cand_wrap = OUT_W'({1'b0, cand} - LIM);

    // Next-state and next-output logic for the draw sequencer.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        winner_d = winner_q;
        last_d   = last_q;
        gnt_d    = '0;
        valid_d  = 1'b0;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed_in == 32'd0) ? SEED : seed_in;
                end else if (rr_found) begin
                    winner_d = rr_win;
                    cnt_d    = CW'(STEPS);
                    tries_d  = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                lfsr_d = lfsr_next(lfsr_q);
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cand_ok || (tries_q == TW'(MAX_TRIES - 1))) begin
                    // Out-of-range on the last try folds down by LIMIT; the
                    // parameter bound guarantees the result is below LIMIT.
                    data_d  = cand_ok ? cand : cand_wrap;
                    valid_d = 1'b1;
                    gnt_d   = NREQ'(1) << winner_q;
                    state_d = S_DONE;
                end else begin
                    tries_d = tries_q + TW'(1);
                    cnt_d   = CW'(STEPS);
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                last_d  = winner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset restores the seed and gives requester 0 priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            cnt_q    <= '0;
            tries_q  <= '0;
            winner_q <= '0;
            last_q   <= PW'(NREQ - 1);
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            tries_q  <= tries_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_valid  = valid_q;
    assign rnd_data   = data_q;
    assign busy       = (state_q != S_IDLE);
    assign lfsr_state = lfsr_q;

endmodule
